// File: rtl/sa_ar_pkg.sv
// Shared types and constants for the AR-channel arbiter.
// No logic; sizes the 4 KB page split and the AXI burst length field.
// Imported by sa_ar_arbiter.
package sa_ar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_ISSUE2 = 2'd2
  } ar_state_e;

  localparam int PAGE_BITS = 12;
  localparam int ARLEN_W   = 8;

endpackage

// File: rtl/sa_rr_arbiter.sv
// Round-robin grant: one-hot grant of the first requester at or after the pointer.
// Combinational grant; the pointer moves to winner+1 on the clock after update.
// No backpressure of its own; the caller asserts update only on an accepted grant.
module sa_rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             update,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr;

  always_comb begin
    logic found;
    int   idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (update) begin
      ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/sa_ar_arbiter.sv
// Arbitrates per-master AR requests onto one slave port; optional 4 KB split via SA_AR_4KB_SPLIT_EN.
// Latency: accepted request appears on s_AR* the next cycle; a split issues two beats back to back.
// Backpressure: masters wait while not IDLE; s_ARREADY_i holds payload; AR_stall_i holds a pending split.
module sa_ar_arbiter
  import sa_ar_pkg::*;
#(
  parameter int MST_AMT         = 3,
  parameter int OUTSTANDING_AMT = 8,
  parameter int MST_ID_W        = $clog2(MST_AMT),
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int TRANS_MST_ID_W  = 5,
  parameter int TRANS_SLV_ID_W  = TRANS_MST_ID_W + MST_ID_W
) (
  input  logic                               ACLK_i,
  input  logic                               ARESET_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]  dsp_ARID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]      dsp_ARADDR_i,
  input  logic [8*MST_AMT-1:0]               dsp_ARLEN_i,
  input  logic [MST_AMT-1:0]                 dsp_ARVALID_i,
  output logic [MST_AMT-1:0]                 dsp_ARREADY_o,
  output logic [TRANS_SLV_ID_W-1:0]          s_ARID_o,
  output logic [ADDR_WIDTH-1:0]              s_ARADDR_o,
  output logic [7:0]                         s_ARLEN_o,
  output logic                               s_ARVALID_o,
  input  logic                               s_ARREADY_i,
  output logic [TRANS_SLV_ID_W-1:0]          AR_AxID_o,
  output logic                               AR_crossing_flag_o,
  output logic                               AR_shift_en_o,
  input  logic                               AR_stall_i
);

  localparam int PAGE_W = ADDR_WIDTH - PAGE_BITS;

  ar_state_e                 state, state_nxt;
  logic [MST_AMT-1:0]        grant;
  logic [MST_ID_W-1:0]       grant_idx;
  logic                      accept;
  logic [TRANS_SLV_ID_W-1:0] id_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [ARLEN_W-1:0]        len_q;

  logic                      split;
  logic                      stall_blk;
  logic [ARLEN_W-1:0]        len1;
  logic [ARLEN_W-1:0]        len2;
  logic [ADDR_WIDTH-1:0]     addr2;

  sa_rr_arbiter #(
    .N     (MST_AMT),
    .IDX_W (MST_ID_W)
  ) u_rr (
    .clk       (ACLK_i),
    .rst       (ARESET_i),
    .req       (dsp_ARVALID_i),
    .update    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Ready is gated by reset too so nothing looks accepted while the block is held.
  assign dsp_ARREADY_o = (state == ST_IDLE && !ARESET_i) ? grant : '0;
  assign accept        = |dsp_ARREADY_o;

  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) begin
      id_q   <= '0;
      addr_q <= '0;
      len_q  <= '0;
    end else if (accept) begin
      id_q   <= {grant_idx, dsp_ARID_i[int'(grant_idx)*TRANS_MST_ID_W +: TRANS_MST_ID_W]};
      addr_q <= dsp_ARADDR_i[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      len_q  <= dsp_ARLEN_i[int'(grant_idx)*ARLEN_W +: ARLEN_W];
    end
  end

`ifdef SA_AR_4KB_SPLIT_EN
  localparam int BYTE_SH = $clog2(DATA_WIDTH / 8);

  logic [ADDR_WIDTH-1:0] span;
  logic [PAGE_W-1:0]     end_page;
  logic [PAGE_W-1:0]     page_q;
  logic [PAGE_BITS:0]    beats1;

  // Bursts are beat-aligned INCR of at most 256 beats, so one page crossing at most.
  assign span     = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << BYTE_SH;
  assign end_page = PAGE_W'((addr_q + span - ADDR_WIDTH'(1)) >> PAGE_BITS);
  assign page_q   = addr_q[ADDR_WIDTH-1:PAGE_BITS];
  assign split    = (page_q != end_page);
  assign beats1   = ((PAGE_BITS+1)'(1 << PAGE_BITS) - {1'b0, addr_q[PAGE_BITS-1:0]}) >> BYTE_SH;
  assign len1     = ARLEN_W'(beats1 - (PAGE_BITS+1)'(1));
  assign len2     = len_q - ARLEN_W'(beats1);
  assign addr2    = {page_q + PAGE_W'(1), {PAGE_BITS{1'b0}}};
  assign stall_blk = split & AR_stall_i;
`else
  logic unused_stall;

  assign unused_stall = AR_stall_i;
  assign split        = 1'b0;
  assign stall_blk    = 1'b0;
  assign len1         = len_q;
  assign len2         = len_q;
  assign addr2        = addr_q;
`endif

  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    s_ARVALID_o        = 1'b0;
    s_ARADDR_o         = addr_q;
    s_ARLEN_o          = len_q;
    AR_crossing_flag_o = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        s_ARVALID_o = !stall_blk;
        if (split) begin
          s_ARLEN_o          = len1;
          AR_crossing_flag_o = 1'b1;
        end
        if (s_ARVALID_o && s_ARREADY_i) state_nxt = split ? ST_ISSUE2 : ST_IDLE;
      end
      ST_ISSUE2: begin
        s_ARVALID_o = 1'b1;
        s_ARADDR_o  = addr2;
        s_ARLEN_o   = len2;
        if (s_ARREADY_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign s_ARID_o      = id_q;
  assign AR_AxID_o     = id_q;
  assign AR_shift_en_o = s_ARVALID_o & s_ARREADY_i;

endmodule

// File: tb/tb_sa_ar_arbiter.sv
// Directed bench for sa_ar_arbiter; expectations follow SA_AR_4KB_SPLIT_EN when it is defined.
module tb_sa_ar_arbiter;

  logic        aclk = 1'b0;
  logic        areset;
  logic [14:0] dsp_arid;
  logic [95:0] dsp_araddr;
  logic [23:0] dsp_arlen;
  logic [2:0]  dsp_arvalid;
  logic [2:0]  dsp_arready;
  logic [6:0]  s_arid;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic        s_arvalid;
  logic        s_arready;
  logic [6:0]  axid;
  logic        cross_flag;
  logic        shift_en;
  logic        stall;

  int vectors = 0;
  int errs    = 0;

  sa_ar_arbiter dut (
    .ACLK_i             (aclk),
    .ARESET_i           (areset),
    .dsp_ARID_i         (dsp_arid),
    .dsp_ARADDR_i       (dsp_araddr),
    .dsp_ARLEN_i        (dsp_arlen),
    .dsp_ARVALID_i      (dsp_arvalid),
    .dsp_ARREADY_o      (dsp_arready),
    .s_ARID_o           (s_arid),
    .s_ARADDR_o         (s_araddr),
    .s_ARLEN_o          (s_arlen),
    .s_ARVALID_o        (s_arvalid),
    .s_ARREADY_i        (s_arready),
    .AR_AxID_o          (axid),
    .AR_crossing_flag_o (cross_flag),
    .AR_shift_en_o      (shift_en),
    .AR_stall_i         (stall)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_mst(input int m, input logic [4:0] id, input logic [31:0] addr,
                         input logic [7:0] len);
    dsp_arid[m*5 +: 5]     = id;
    dsp_araddr[m*32 +: 32] = addr;
    dsp_arlen[m*8 +: 8]    = len;
  endtask

  initial begin
    areset      = 1'b1;
    dsp_arid    = '0;
    dsp_araddr  = '0;
    dsp_arlen   = '0;
    dsp_arvalid = '0;
    s_arready   = 1'b0;
    stall       = 1'b0;
    #1;
    chk("rst_valid", 32'(s_arvalid), 32'd0);
    chk("rst_ready", 32'(dsp_arready), 32'd0);
    chk("rst_shift", 32'(shift_en), 32'd0);
    chk("rst_cross", 32'(cross_flag), 32'd0);
    chk("rst_id", 32'(s_arid), 32'd0);
    chk("rst_addr", s_araddr, 32'd0);
    chk("rst_len", 32'(s_arlen), 32'd0);
    step();
    step();
    areset = 1'b0;

    // Round robin with all masters requesting: 0,1,2,0.
    for (int m = 0; m < 3; m++) set_mst(m, 5'(8 + m), 32'(m * 32'h100), 8'd0);
    dsp_arvalid = 3'b111;
    s_arready   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_ready", 32'(dsp_arready), 32'(3'b001 << (k % 3)));
      step();
      #1;
      chk("rr_valid", 32'(s_arvalid), 32'd1);
      chk("rr_mst", 32'(s_arid[6:5]), 32'(k % 3));
      chk("rr_id", 32'(s_arid[4:0]), 32'(8 + k % 3));
      chk("rr_ready_busy", 32'(dsp_arready), 32'd0);
      chk("rr_shift", 32'(shift_en), 32'd1);
      step();
    end
    dsp_arvalid = '0;
    step();

    // Single aligned request from master 1.
    set_mst(1, 5'h3, 32'h1000, 8'd7);
    dsp_arvalid = 3'b010;
    #1;
    chk("m1_ready", 32'(dsp_arready), 32'b010);
    step();
    dsp_arvalid = '0;
    #1;
    chk("m1_valid", 32'(s_arvalid), 32'd1);
    chk("m1_id", 32'(s_arid), 32'h23);
    chk("m1_axid", 32'(axid), 32'h23);
    chk("m1_addr", s_araddr, 32'h1000);
    chk("m1_len", 32'(s_arlen), 32'd7);
    chk("m1_cross", 32'(cross_flag), 32'd0);
    chk("m1_shift", 32'(shift_en), 32'd1);
    step();
    #1;
    chk("m1_done_valid", 32'(s_arvalid), 32'd0);
    chk("m1_done_shift", 32'(shift_en), 32'd0);

    // Page-crossing burst from master 0 with stall and slave backpressure.
    set_mst(0, 5'h1A, 32'h0FF0, 8'd7);
    dsp_arvalid = 3'b001;
    s_arready   = 1'b0;
    stall       = 1'b1;
    #1;
    chk("x_ready", 32'(dsp_arready), 32'b001);
    step();
    dsp_arvalid = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
`ifdef SA_AR_4KB_SPLIT_EN
      chk("x_stall_valid", 32'(s_arvalid), 32'd0);
      chk("x_stall_cross", 32'(cross_flag), 32'd1);
`else
      chk("x_stall_valid", 32'(s_arvalid), 32'd1);
      chk("x_stall_cross", 32'(cross_flag), 32'd0);
`endif
      chk("x_stall_shift", 32'(shift_en), 32'd0);
      step();
    end
    stall = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("x_hold_valid", 32'(s_arvalid), 32'd1);
      chk("x_hold_addr", s_araddr, 32'h0FF0);
      chk("x_hold_id", 32'(s_arid), 32'h1A);
`ifdef SA_AR_4KB_SPLIT_EN
      chk("x_hold_len", 32'(s_arlen), 32'd3);
      chk("x_hold_cross", 32'(cross_flag), 32'd1);
`else
      chk("x_hold_len", 32'(s_arlen), 32'd7);
      chk("x_hold_cross", 32'(cross_flag), 32'd0);
`endif
      step();
    end
    s_arready = 1'b1;
    #1;
    chk("x_first_shift", 32'(shift_en), 32'd1);
    step();
`ifdef SA_AR_4KB_SPLIT_EN
    stall = 1'b1;
    #1;
    chk("x2_valid", 32'(s_arvalid), 32'd1);
    chk("x2_addr", s_araddr, 32'h1000);
    chk("x2_len", 32'(s_arlen), 32'd3);
    chk("x2_cross", 32'(cross_flag), 32'd0);
    chk("x2_id", 32'(axid), 32'h1A);
    chk("x2_shift", 32'(shift_en), 32'd1);
    step();
    stall = 1'b0;
`endif
    #1;
    chk("x_done_valid", 32'(s_arvalid), 32'd0);

    // Reset in the middle of a transaction (second half when splitting).
    set_mst(2, 5'h05, 32'h0FF0, 8'd7);
    dsp_arvalid = 3'b100;
    #1;
    chk("r_ready", 32'(dsp_arready), 32'b100);
    step();
    dsp_arvalid = '0;
`ifdef SA_AR_4KB_SPLIT_EN
    #1;
    chk("r_cross", 32'(cross_flag), 32'd1);
    step();
    s_arready = 1'b0;
    #1;
    chk("r_issue2_addr", s_araddr, 32'h1000);
`else
    s_arready = 1'b0;
    #1;
`endif
    chk("r_busy_valid", 32'(s_arvalid), 32'd1);
    for (int m = 0; m < 3; m++) set_mst(m, 5'(16 + m), 32'h2000, 8'd0);
    dsp_arvalid = 3'b111;
    areset      = 1'b1;
    #1;
    chk("r_valid", 32'(s_arvalid), 32'd0);
    chk("r_dready", 32'(dsp_arready), 32'd0);
    chk("r_shift", 32'(shift_en), 32'd0);
    chk("r_crossf", 32'(cross_flag), 32'd0);
    chk("r_id", 32'(s_arid), 32'd0);
    chk("r_addr", s_araddr, 32'd0);
    chk("r_len", 32'(s_arlen), 32'd0);
    step();
    areset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(dsp_arready), 32'b001);
    step();
    s_arready = 1'b1;
    #1;
    chk("post_rst_valid", 32'(s_arvalid), 32'd1);
    chk("post_rst_mst", 32'(s_arid), 32'h10);
    step();
    dsp_arvalid = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
